// File: rtl/brs_pkg.sv
// Shared types and constants for the BRS operand loader.
// Holds the loader FSM encoding and the reset levels used by the strobe path.
package brs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_A = 2'd1,
    HOLD  = 2'd2
  } brs_state_t;

  localparam int BRS_WIDTH = 8;

  // Strobe path resets high so a strobe held through reset cannot look like a new edge.
  localparam logic STB_SYNC_RST = 1'b1;
  localparam logic STB_PREV_RST = 1'b1;
  localparam logic DB_LEVEL_RST = 1'b1;

endpackage

// File: rtl/brs_sync.sv
// Parameterised multi-flop synchroniser with a configurable reset value.
module brs_sync #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_chain [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_chain[i] <= RST_VAL;
      end
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/brs_operand_loader.sv
// Captures operand A then B from an asynchronous pin bus on strobe edges and offers the pair downstream.
// Optional strobe debouncer enabled by defining BRS_LOADER_DEBOUNCE_EN.
module brs_operand_loader
  import brs_pkg::*;
#(
  parameter int WIDTH           = BRS_WIDTH,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             strobe_in,
  input  logic             op_ready,
  input  logic             clear_err,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  output logic             busy,
  output logic             err_overrun
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("brs_operand_loader: SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("brs_operand_loader: DEBOUNCE_CYCLES must be at least 1");
  end

  logic             w_stb_sync;
  logic             w_stb_level;
  logic             w_stb_rise;
  logic [WIDTH-1:0] w_data_sync;

  brs_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(STB_SYNC_RST)) u_stb_sync (
    .clk (clk),
    .rst (rst),
    .i_d (strobe_in),
    .o_q (w_stb_sync)
  );

  brs_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_data_sync (
    .clk (clk),
    .rst (rst),
    .i_d (data_in),
    .o_q (w_data_sync)
  );

`ifdef BRS_LOADER_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [DB_W-1:0] r_db_cnt;
  logic            r_db_level;

  // Counter tracks how long the raw level has disagreed with the accepted one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_cnt   <= '0;
      r_db_level <= DB_LEVEL_RST;
    end else if (w_stb_sync == r_db_level) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      r_db_cnt   <= '0;
      r_db_level <= w_stb_sync;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  assign w_stb_level = r_db_level;
`else
  assign w_stb_level = w_stb_sync;
`endif

  logic r_stb_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stb_prev <= STB_PREV_RST;
    end else begin
      r_stb_prev <= w_stb_level;
    end
  end

  assign w_stb_rise = w_stb_level & ~r_stb_prev;

  brs_state_t       r_state;
  brs_state_t       w_next_state;
  logic             w_load_a;
  logic             w_load_b;
  logic             w_set_err;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_op_valid;
  logic             r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A strobe in HOLD is only a new A when the pair is released in the same cycle.
  always_comb begin
    w_next_state = r_state;
    w_load_a     = 1'b0;
    w_load_b     = 1'b0;
    w_set_err    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_stb_rise) begin
          w_load_a     = 1'b1;
          w_next_state = GOT_A;
        end
      end
      GOT_A: begin
        if (w_stb_rise) begin
          w_load_b     = 1'b1;
          w_next_state = HOLD;
        end
      end
      HOLD: begin
        if (op_ready) begin
          if (w_stb_rise) begin
            w_load_a     = 1'b1;
            w_next_state = GOT_A;
          end else begin
            w_next_state = IDLE;
          end
        end else if (w_stb_rise) begin
          w_set_err = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_load_a) r_op_a <= w_data_sync;
      if (w_load_b) r_op_b <= w_data_sync;
      r_op_valid <= (w_next_state == HOLD);
      if (w_set_err) begin
        r_err <= 1'b1;
      end else if (clear_err) begin
        r_err <= 1'b0;
      end
    end
  end

  assign op_a        = r_op_a;
  assign op_b        = r_op_b;
  assign op_valid    = r_op_valid;
  assign busy        = (r_state == GOT_A) || (r_state == HOLD);
  assign err_overrun = r_err;

endmodule

// File: tb/tb_brs_operand_loader.sv
// Scoreboard bench for brs_operand_loader; honours BRS_LOADER_DEBOUNCE_EN when defined.
module tb_brs_operand_loader;

`ifdef BRS_LOADER_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif
  localparam int HI = 3 + DB;
  localparam int LO = 3 + DB;

  logic       clk;
  logic       rst;
  logic [7:0] dataIn;
  logic       strobeIn;
  logic       opReady;
  logic       clearErr;
  logic [7:0] opA;
  logic [7:0] opB;
  logic       opValid;
  logic       busy;
  logic       errOverrun;

  int vectors     = 0;
  int miscompares = 0;
  logic [15:0] expQ [$];

  brs_operand_loader #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (dataIn),
    .strobe_in   (strobeIn),
    .op_ready    (opReady),
    .clear_err   (clearErr),
    .op_a        (opA),
    .op_b        (opB),
    .op_valid    (opValid),
    .busy        (busy),
    .err_overrun (errOverrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input int hi, input int lo);
    dataIn   = d;
    strobeIn = 1'b1;
    repeat (hi) tick();
    strobeIn = 1'b0;
    repeat (lo) tick();
  endtask

  // Monitor: every accepted pair must match the oldest expected pair.
  always @(negedge clk) begin
    if (!rst && opValid && opReady) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_pair: got a=0x%0h b=0x%0h, expected no handshake", opA, opB);
      end else begin
        logic [15:0] exp;
        exp = expQ.pop_front();
        checkOutput("pair_a", {24'd0, opA}, {24'd0, exp[15:8]});
        checkOutput("pair_b", {24'd0, opB}, {24'd0, exp[7:0]});
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst      = 1'b1;
    dataIn   = 8'h00;
    strobeIn = 1'b0;
    opReady  = 1'b0;
    clearErr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    $display("[TB] reset state");
    checkOutput("reset_op_a", 32'(opA), 32'h00);
    checkOutput("reset_op_b", 32'(opB), 32'h00);
    checkOutput("reset_op_valid", 32'(opValid), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_err", 32'(errOverrun), 32'h0);

`ifdef BRS_LOADER_DEBOUNCE_EN
    $display("[TB] debounce glitch");
    strobeIn = 1'b1;
    repeat (2) tick();
    strobeIn = 1'b0;
    repeat (10) tick();
    checkOutput("glitch_busy", 32'(busy), 32'h0);
    checkOutput("glitch_op_a", 32'(opA), 32'h00);
`endif

    $display("[TB] basic pair");
    opReady = 1'b1;
    applyStimulus(8'h12, HI, LO);
    checkOutput("basic_got_a_busy", 32'(busy), 32'h1);
    checkOutput("basic_got_a_valid", 32'(opValid), 32'h0);
    checkOutput("basic_got_a_op_a", 32'(opA), 32'h12);
    expQ.push_back(16'h1234);
    dataIn   = 8'h34;
    strobeIn = 1'b1;
    for (int i = 0; i <= 2 + DB; i++) begin
      tick();
      checkOutput($sformatf("basic_latency_edge%0d", i), 32'(opValid), (i == 2 + DB) ? 32'h1 : 32'h0);
    end
    tick();
    checkOutput("basic_valid_one_cycle", 32'(opValid), 32'h0);
    strobeIn = 1'b0;
    repeat (LO) tick();
    checkOutput("basic_idle_busy", 32'(busy), 32'h0);

    $display("[TB] backpressure");
    opReady = 1'b0;
    expQ.push_back(16'hFF01);
    applyStimulus(8'hFF, HI, LO);
    applyStimulus(8'h01, HI, LO);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_valid_held", 32'(opValid), 32'h1);
      checkOutput("bp_op_a_stable", 32'(opA), 32'hFF);
      checkOutput("bp_op_b_stable", 32'(opB), 32'h01);
      tick();
    end
    opReady = 1'b1;
    tick();
    opReady = 1'b0;
    checkOutput("bp_valid_drop", 32'(opValid), 32'h0);

    $display("[TB] overrun");
    expQ.push_back(16'h2143);
    applyStimulus(8'h21, HI, LO);
    applyStimulus(8'h43, HI, LO);
    checkOutput("ovr_pre_valid", 32'(opValid), 32'h1);
    checkOutput("ovr_pre_err", 32'(errOverrun), 32'h0);
    applyStimulus(8'hAA, HI, LO);
    checkOutput("ovr_err_set", 32'(errOverrun), 32'h1);
    checkOutput("ovr_op_a_kept", 32'(opA), 32'h21);
    checkOutput("ovr_op_b_kept", 32'(opB), 32'h43);
    checkOutput("ovr_valid_kept", 32'(opValid), 32'h1);
    clearErr = 1'b1;
    tick();
    clearErr = 1'b0;
    checkOutput("ovr_err_cleared", 32'(errOverrun), 32'h0);

    $display("[TB] strobe coincident with handshake");
    dataIn   = 8'h55;
    strobeIn = 1'b1;
    repeat (2 + DB) tick();
    opReady = 1'b1;
    tick();
    opReady = 1'b0;
    checkOutput("sim_op_a", 32'(opA), 32'h55);
    checkOutput("sim_busy", 32'(busy), 32'h1);
    checkOutput("sim_valid", 32'(opValid), 32'h0);
    checkOutput("sim_no_err", 32'(errOverrun), 32'h0);
    strobeIn = 1'b0;
    repeat (LO) tick();
    expQ.push_back(16'h5566);
    applyStimulus(8'h66, HI, LO);
    checkOutput("sim_hold_valid", 32'(opValid), 32'h1);

    $display("[TB] clear coincident with overrun");
    dataIn   = 8'hEE;
    strobeIn = 1'b1;
    repeat (2 + DB) tick();
    clearErr = 1'b1;
    tick();
    clearErr = 1'b0;
    checkOutput("setwins_err", 32'(errOverrun), 32'h1);
    checkOutput("setwins_op_a", 32'(opA), 32'h55);
    checkOutput("setwins_op_b", 32'(opB), 32'h66);
    strobeIn = 1'b0;
    repeat (LO) tick();
    opReady = 1'b1;
    tick();
    opReady = 1'b0;
    checkOutput("setwins_release", 32'(opValid), 32'h0);
    clearErr = 1'b1;
    tick();
    clearErr = 1'b0;

    $display("[TB] reset mid-operation");
    dataIn   = 8'h77;
    strobeIn = 1'b1;
    repeat (HI) tick();
    checkOutput("rst_pre_busy", 32'(busy), 32'h1);
    checkOutput("rst_pre_op_a", 32'(opA), 32'h77);
    rst = 1'b1;
    repeat (2) tick();
    checkOutput("rst_op_a", 32'(opA), 32'h00);
    checkOutput("rst_op_b", 32'(opB), 32'h00);
    checkOutput("rst_valid", 32'(opValid), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_err", 32'(errOverrun), 32'h0);
    rst = 1'b0;
    repeat (HI + LO) tick();
    checkOutput("rst_no_false_edge_busy", 32'(busy), 32'h0);
    checkOutput("rst_no_false_edge_op_a", 32'(opA), 32'h00);
    strobeIn = 1'b0;
    repeat (LO) tick();
    opReady = 1'b1;
    expQ.push_back(16'h8899);
    applyStimulus(8'h88, HI, LO);
    applyStimulus(8'h99, HI, LO);
    opReady = 1'b0;
    checkOutput("rst_after_op_a", 32'(opA), 32'h88);
    checkOutput("rst_after_op_b", 32'(opB), 32'h99);
    checkOutput("rst_after_busy", 32'(busy), 32'h0);

    repeat (3) tick();
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
